// File: rtl/bf_pair_feeder.sv
// Butterfly operand feeder: buffers the first half of each N-sample frame and pairs
// x[k] with x[k+N/2] into a registered output. Optional out_last port under BF_PAIR_LAST_EN.
module bf_pair_feeder #(
  parameter int DW = 24,
  parameter int N  = 16,
  parameter int AW = $clog2(N/2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
`ifdef BF_PAIR_LAST_EN
  output logic          out_last,
`endif
  output logic [AW-1:0] out_idx
);

  localparam int HALF = N / 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(HALF - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          out_valid_q;
  logic [DW-1:0] out_a_q;
  logic [DW-1:0] out_b_q;
  logic [AW-1:0] out_idx_q;
  logic [DW-1:0] mem_q [HALF];

  logic in_fire;
  logic cnt_last;

  // In PAIR a new sample needs a free (or draining) output slot; FILL never touches it.
  always_comb begin
    in_ready = (state_q == FILL) ? 1'b1 : (!out_valid_q || out_ready);
  end

  assign in_fire  = in_valid && in_ready;
  assign cnt_last = (cnt_q == LAST_IDX);

  // NOTE: the buffer has no reset; every word is written in FILL before PAIR reads it.
  always_ff @(posedge clk) begin
    if (in_fire && state_q == FILL) begin
      mem_q[cnt_q] <= in_data;
    end
  end

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_idx_q   <= '0;
    end else begin
      if (in_fire) begin
        cnt_q <= cnt_last ? '0 : cnt_q + AW'(1);
        if (cnt_last) begin
          state_q <= (state_q == FILL) ? PAIR : FILL;
        end
      end

      if (in_fire && state_q == PAIR) begin
        out_a_q     <= mem_q[cnt_q];
        out_b_q     <= in_data;
        out_idx_q   <= cnt_q;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef BF_PAIR_LAST_EN
  logic out_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last_q <= 1'b0;
    end else if (in_fire && state_q == PAIR) begin
      out_last_q <= cnt_last;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_idx   = out_idx_q;

endmodule

// File: doc/bf_pair_feeder.md
Name: bf_pair_feeder

Overview:
- Upstream stage of the combinational Butterfly. Takes a stream of packed complex samples, one frame of N samples at a time.
- Emits registered operand pairs A = x[k], B = x[k+N/2] for k = 0..N/2-1, which drive Butterfly inputs A/B directly.
- Uses a single-port-per-direction buffer of N/2 words. Valid/ready handshakes on both sides.

Parameters:
- DW, 24, sample width; packed {real[DW/2-1:0], imag[DW/2-1:0]}, treated as opaque bits.
- N, 16, frame length; power of two, 4 ≤ N ≤ 1024.
- AW, $clog2(N/2), buffer address / pair-index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a sample
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DW  input sample x[n]
- out_valid  output  1  out_a/out_b hold a pair
- out_ready  input  1  downstream consumes the pair this cycle
- out_a  output  DW  x[k] (Butterfly A)
- out_b  output  DW  x[k+N/2] (Butterfly B)
- out_idx  output  AW  pair index k

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=FILL, cnt=0, out_valid=0, out_a=0, out_b=0, out_idx=0. Buffer contents are not reset.
- A transfer occurs on a rising edge with valid&ready high on the same side.
- State FILL:
  - in_ready=1 unconditionally.
  - Each accepted sample is written to buf[cnt], and cnt increments.
  - When the accepted sample has cnt=N/2-1: cnt←0, state←PAIR.
  - FILL never touches the output register; an earlier pair may still be pending there.
- State PAIR:
  - in_ready = !out_valid | out_ready.
  - On accept: out_a←buf[cnt], out_b←in_data, out_idx←cnt, out_valid←1, cnt increments.
  - When the accepted sample has cnt=N/2-1: cnt←0, state←FILL.
- Output register:
  - out_valid clears on out_ready when no new pair is loaded that cycle.
  - If consume and load happen together, the new pair replaces the old one with no bubble.
  - Data is held stable while out_valid & !out_ready.
- Latency: 1 clock from accepting x[k+N/2] to out_valid showing pair k.
- Throughput: one sample per clock. N/2 pairs per N input cycles at full rate.
- Buffer safety: buf[k] is read at the same edge it is consumed. The next frame's FILL write to buf[k] happens on a later edge, so back-to-back frames need no stall.
- in_valid=0 at any point: the block holds its state; no gaps are inserted or required.
- in_data is ignored when in_ready=0.
- Wrap: cnt wraps at N/2-1 → 0 in both states. Frames repeat indefinitely.
- Reset mid-frame: a partial frame is discarded, a pending pair is dropped (out_valid←0), and the next accepted sample is treated as x[0].

Optional Feature:
- Macro BF_PAIR_LAST_EN.
- When defined: adds port out_last (output, 1). It is registered alongside the pair, equals 1 when out_idx=N/2-1 is loaded, and resets to 0.
- When undefined: the port is absent and all other behaviour is identical.

Test Plan:
- Reset and idle: rst_n=0 for 3 clks, then 1, with in_valid=0 → out_valid=0, in_ready=1, out_a=out_b=0.
- Single frame, N=16, out_ready=1, in_data=n for n=0..15 on consecutive clks → pairs (0,8),(1,9)…(7,15), out_idx 0..7. First out_valid is 1 clk after sample 8 is accepted.
- Backpressure: out_ready=0 while pairs arrive → in_ready=0 after the first pair loads and the (0,8) pair is held stable. Raising out_ready releases pairs in order with none lost.
- Back-to-back frames: samples 0..31 continuous, out_ready=1 → second frame yields (16,24)…(23,31), with no stall on in_ready and no corruption from overlapping FILL.
- Reset mid-frame: assert rst_n=0 after sample 11 of frame 1, then stream 100..115 → out_valid drops immediately and the outputs are (100,108)…(107,115).
- BF_PAIR_LAST_EN defined, one frame as in the second test → out_last=1 only with pair (7,15).
